// File: rtl/w_stage_pkg.sv
// Shared widths and debug-FSM state encoding for the writeback stage.
package w_stage_pkg;
  localparam int XLEN      = 32;
  localparam int REG_COUNT = 32;
  localparam int REG_SEL_W = 5;
  localparam int INSTRET_W = 64;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;
endpackage

// File: rtl/w_regfile.sv
// Integer register file: two combinational read ports, one write port, x0 hardwired to zero.
module w_regfile
  import w_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_we,
  input  logic [REG_SEL_W-1:0] i_waddr,
  input  logic [XLEN-1:0]      i_wdata,
  input  logic [REG_SEL_W-1:0] i_raddr1,
  input  logic [REG_SEL_W-1:0] i_raddr2,
  output logic [XLEN-1:0]      o_rdata1,
  output logic [XLEN-1:0]      o_rdata2
);

  logic [XLEN-1:0] r_regs [REG_COUNT];

  // NOTE: the array is reset because architectural state must clear on reset;
  // this rules out a RAM macro, so the file is built from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/w_stage.sv
// Writeback stage: commits results to the register file, counts retired instructions
// and runs the RUN/HALT/STEP debug FSM. Define WB_BYPASS_EN for same-cycle read bypass.
module w_stage
  import w_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 c_ready,
  input  logic [XLEN-1:0]      cw_pc,
  input  logic [REG_SEL_W-1:0] cw_write_sel,
  input  logic [XLEN-1:0]      cw_result,
  input  logic                 cw_is_wb,
  output logic                 w_ready,
  input  logic [REG_SEL_W-1:0] rs1_sel,
  input  logic [REG_SEL_W-1:0] rs2_sel,
  output logic [XLEN-1:0]      rs1_data,
  output logic [XLEN-1:0]      rs2_data,
  input  logic                 halt_req,
  input  logic                 step_req,
  input  logic                 resume_req,
  output logic                 halted,
  output logic [INSTRET_W-1:0] instret,
  output logic [XLEN-1:0]      last_pc
);

  state_t                r_state;
  state_t                w_next_state;
  logic [INSTRET_W-1:0]  r_instret;
  logic [XLEN-1:0]       r_last_pc;
  logic                  w_we;
  logic [XLEN-1:0]       w_rf_rd1;
  logic [XLEN-1:0]       w_rf_rd2;

  // A commit is accepted whenever c_ready is high, even in HALT: the bundle is already in flight.
  assign w_we = c_ready && cw_is_wb;

  w_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_we),
    .i_waddr  (cw_write_sel),
    .i_wdata  (cw_result),
    .i_raddr1 (rs1_sel),
    .i_raddr2 (rs2_sel),
    .o_rdata1 (w_rf_rd1),
    .o_rdata2 (w_rf_rd2)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_instret <= '0;
      r_last_pc <= '0;
    end else begin
      r_state <= w_next_state;
      if (c_ready) begin
        r_instret <= r_instret + INSTRET_W'(1);
        r_last_pc <= cw_pc;
      end
    end
  end

  // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_RUN:  if (halt_req) w_next_state = ST_HALT;
      ST_HALT: begin
        if (resume_req)    w_next_state = ST_RUN;
        else if (step_req) w_next_state = ST_STEP;
      end
      ST_STEP: w_next_state = ST_HALT;
      default: w_next_state = ST_RUN;
    endcase
  end

  assign w_ready = (r_state != ST_HALT);
  assign halted  = (r_state == ST_HALT);
  assign instret = r_instret;
  assign last_pc = r_last_pc;

`ifdef WB_BYPASS_EN
  logic w_hit1;
  logic w_hit2;
  assign w_hit1   = w_we && (cw_write_sel != '0) && (rs1_sel == cw_write_sel);
  assign w_hit2   = w_we && (cw_write_sel != '0) && (rs2_sel == cw_write_sel);
  assign rs1_data = w_hit1 ? cw_result : w_rf_rd1;
  assign rs2_data = w_hit2 ? cw_result : w_rf_rd2;
`else
  assign rs1_data = w_rf_rd1;
  assign rs2_data = w_rf_rd2;
`endif

endmodule

// File: tb/tb_w_stage.sv
// Self-checking bench for w_stage: directed vector table, corner sequences, and
// randomized traffic compared against a behavioural model.
module tb_w_stage;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        c_ready;
  logic [31:0] cw_pc;
  logic [4:0]  cw_write_sel;
  logic [31:0] cw_result;
  logic        cw_is_wb;
  logic        w_ready;
  logic [4:0]  rs1_sel;
  logic [4:0]  rs2_sel;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        halt_req;
  logic        step_req;
  logic        resume_req;
  logic        halted;
  logic [63:0] instret;
  logic [31:0] last_pc;

  int n_checks = 0;
  int n_errors = 0;

  w_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .c_ready      (c_ready),
    .cw_pc        (cw_pc),
    .cw_write_sel (cw_write_sel),
    .cw_result    (cw_result),
    .cw_is_wb     (cw_is_wb),
    .w_ready      (w_ready),
    .rs1_sel      (rs1_sel),
    .rs2_sel      (rs2_sel),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .halt_req     (halt_req),
    .step_req     (step_req),
    .resume_req   (resume_req),
    .halted       (halted),
    .instret      (instret),
    .last_pc      (last_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          c_ready;
    logic [31:0] pc;
    logic [4:0]  sel;
    logic [31:0] result;
    bit          is_wb;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    bit          halt;
    bit          step;
    bit          resume;
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;
    bit          exp_wr;
    bit          exp_halted;
    logic [63:0] exp_instret;
    logic [31:0] exp_last_pc;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    c_ready      = v.c_ready;
    cw_pc        = v.pc;
    cw_write_sel = v.sel;
    cw_result    = v.result;
    cw_is_wb     = v.is_wb;
    rs1_sel      = v.rs1;
    rs2_sel      = v.rs2;
    halt_req     = v.halt;
    step_req     = v.step;
    resume_req   = v.resume;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, " rs1_data"}, 64'(rs1_data), 64'(v.exp_rs1));
    check({tag, " rs2_data"}, 64'(rs2_data), 64'(v.exp_rs2));
    check({tag, " w_ready"},  64'(w_ready),  64'(v.exp_wr));
    check({tag, " halted"},   64'(halted),   64'(v.exp_halted));
    check({tag, " instret"},  instret,       v.exp_instret);
    check({tag, " last_pc"},  64'(last_pc),  64'(v.exp_last_pc));
  endtask

  function automatic vec_t idle(input logic [4:0] rs1, input logic [4:0] rs2);
    vec_t v;
    v = '{default: '0};
    v.rs1 = rs1;
    v.rs2 = rs2;
    return v;
  endfunction

  // Behavioural model: architectural registers, counters and a debug mode flag pair.
  logic [31:0] m_regs [32];
  logic [63:0] m_instret;
  logic [31:0] m_last_pc;
  bit          m_halted;
  bit          m_stepping;

  function automatic logic [31:0] m_read(input logic [4:0] rs, input vec_t v);
    if (rs == 0) return 32'h0;
    if (BYP && v.c_ready && v.is_wb && v.sel == rs) return v.result;
    return m_regs[rs];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_instret  = 64'h0;
    m_last_pc  = 32'h0;
    m_halted   = 1'b0;
    m_stepping = 1'b0;
  endtask

  task automatic model_edge(input vec_t v);
    if (v.c_ready) begin
      if (v.is_wb && v.sel != 0) m_regs[v.sel] = v.result;
      m_instret = m_instret + 64'd1;
      m_last_pc = v.pc;
    end
    if (m_stepping) begin
      m_stepping = 1'b0;
      m_halted   = 1'b1;
    end else if (m_halted) begin
      if (v.resume) m_halted = 1'b0;
      else if (v.step) begin
        m_halted   = 1'b0;
        m_stepping = 1'b1;
      end
    end else if (v.halt) begin
      m_halted = 1'b1;
    end
  endtask

  initial begin
    vec_t v;
    bit   prev_wr;

    rst_n = 1'b0;
    drive(idle(5'd0, 5'd0));

    tbl[0]  = '{1'b0, 32'h0,  5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0,
                32'h0, 32'h0, 1'b1, 1'b0, 64'd0, 32'h0};
    tbl[1]  = '{1'b1, 32'h10, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0,
                BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 1'b1, 1'b0, 64'd0, 32'h0};
    tbl[2]  = '{1'b0, 32'h0,  5'd0, 32'h0,        1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0,
                32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 64'd1, 32'h10};
    tbl[3]  = '{1'b1, 32'h14, 5'd0, 32'h1234,     1'b1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0,
                32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 64'd1, 32'h10};
    tbl[4]  = '{1'b0, 32'h0,  5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0,
                32'h0, 32'h0, 1'b1, 1'b0, 64'd2, 32'h14};
    tbl[5]  = '{1'b1, 32'h18, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd5, 5'd7, 1'b0, 1'b0, 1'b0,
                32'hDEADBEEF, BYP ? 32'hA5A5A5A5 : 32'h0, 1'b1, 1'b0, 64'd2, 32'h14};
    tbl[6]  = '{1'b1, 32'h1C, 5'd9, 32'h55,       1'b0, 5'd9, 5'd7, 1'b0, 1'b0, 1'b0,
                32'h0, 32'hA5A5A5A5, 1'b1, 1'b0, 64'd3, 32'h18};
    tbl[7]  = '{1'b0, 32'h0,  5'd0, 32'h0,        1'b0, 5'd9, 5'd7, 1'b0, 1'b0, 1'b0,
                32'h0, 32'hA5A5A5A5, 1'b1, 1'b0, 64'd4, 32'h1C};
    tbl[8]  = '{1'b1, 32'h20, 5'd3, 32'h333,      1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0,
                BYP ? 32'h333 : 32'h0, 32'h0, 1'b1, 1'b0, 64'd4, 32'h1C};
    tbl[9]  = '{1'b1, 32'h24, 5'd4, 32'h444,      1'b1, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0,
                32'h333, BYP ? 32'h444 : 32'h0, 1'b0, 1'b1, 64'd5, 32'h20};
    tbl[10] = '{1'b0, 32'h0,  5'd0, 32'h0,        1'b0, 5'd4, 5'd3, 1'b0, 1'b1, 1'b0,
                32'h444, 32'h333, 1'b0, 1'b1, 64'd6, 32'h24};
    tbl[11] = '{1'b0, 32'h0,  5'd0, 32'h0,        1'b0, 5'd4, 5'd3, 1'b1, 1'b0, 1'b1,
                32'h444, 32'h333, 1'b1, 1'b0, 64'd6, 32'h24};
    tbl[12] = '{1'b1, 32'h28, 5'd6, 32'h666,      1'b1, 5'd6, 5'd3, 1'b0, 1'b0, 1'b0,
                BYP ? 32'h666 : 32'h0, 32'h333, 1'b0, 1'b1, 64'd6, 32'h24};
    tbl[13] = '{1'b0, 32'h0,  5'd0, 32'h0,        1'b0, 5'd6, 5'd0, 1'b0, 1'b1, 1'b1,
                32'h666, 32'h0, 1'b0, 1'b1, 64'd7, 32'h28};
    tbl[14] = '{1'b0, 32'h0,  5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0,
                32'h0, 32'h0, 1'b1, 1'b0, 64'd7, 32'h28};
    tbl[15] = '{1'b0, 32'h0,  5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0,
                32'h0, 32'h0, 1'b1, 1'b0, 64'd7, 32'h28};
    tbl[16] = '{1'b0, 32'h0,  5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1,
                32'h0, 32'h0, 1'b1, 1'b0, 64'd7, 32'h28};
    tbl[17] = '{1'b0, 32'h0,  5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1,
                32'h0, 32'h0, 1'b0, 1'b1, 64'd7, 32'h28};
    tbl[18] = '{1'b0, 32'h0,  5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0,
                32'h0, 32'h0, 1'b1, 1'b0, 64'd7, 32'h28};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      check_all($sformatf("row%0d", i), tbl[i]);
      @(posedge clk);
      #1;
    end

    // instret wrap: preload near the top of the 64-bit range.
    dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFE;
    v = idle(5'd10, 5'd11);
    v.c_ready = 1'b1; v.pc = 32'h100; v.sel = 5'd10; v.result = 32'hAAAA; v.is_wb = 1'b1;
    drive(v);
    @(negedge clk);
    check("wrap pre1 instret", instret, 64'hFFFF_FFFF_FFFF_FFFE);
    @(posedge clk);
    #1;
    v.pc = 32'h104; v.sel = 5'd11; v.result = 32'hBBBB;
    drive(v);
    @(negedge clk);
    check("wrap pre2 instret", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk);
    #1;
    drive(idle(5'd10, 5'd11));
    @(negedge clk);
    check("wrap instret", instret, 64'h0);
    check("wrap last_pc", 64'(last_pc), 64'h104);
    check("wrap x10", 64'(rs1_data), 64'hAAAA);
    check("wrap x11", 64'(rs2_data), 64'hBBBB);

    // Enter HALT, then assert reset mid-cycle with a commit presented.
    v = idle(5'd10, 5'd11);
    v.halt = 1'b1;
    @(posedge clk);
    #1;
    drive(v);
    @(posedge clk);
    #1;
    drive(idle(5'd10, 5'd11));
    @(negedge clk);
    check("pre-reset halted", 64'(halted), 64'h1);
    @(posedge clk);
    #2;
    v = idle(5'd10, 5'd11);
    v.c_ready = 1'b1; v.pc = 32'h200; v.sel = 5'd12; v.result = 32'hCCCC; v.is_wb = 1'b1;
    drive(v);
    rst_n = 1'b0;
    #1;
    check("async rst instret", instret, 64'h0);
    check("async rst last_pc", 64'(last_pc), 64'h0);
    check("async rst x10", 64'(rs1_data), 64'h0);
    check("async rst x11", 64'(rs2_data), 64'h0);
    check("async rst w_ready", 64'(w_ready), 64'h1);
    check("async rst halted", 64'(halted), 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(idle(5'd12, 5'd0));
    #1;
    check("dropped commit x12", 64'(rs1_data), 64'h0);
    check("dropped commit instret", instret, 64'h0);
    check("dropped commit last_pc", 64'(last_pc), 64'h0);

    // Randomized traffic against the model, starting from a clean reset.
    model_reset();
    prev_wr = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 600; n++) begin
      v = idle(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      v.c_ready = prev_wr && ($urandom_range(0, 3) != 0);
      v.pc      = $urandom;
      v.sel     = 5'($urandom_range(0, 31));
      v.result  = $urandom;
      v.is_wb   = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) == 0) v.rs1 = v.sel;
      if ($urandom_range(0, 3) == 0) v.rs2 = v.sel;
      v.halt    = ($urandom_range(0, 7) == 0);
      v.step    = ($urandom_range(0, 5) == 0);
      v.resume  = ($urandom_range(0, 9) == 0);
      v.exp_rs1     = m_read(v.rs1, v);
      v.exp_rs2     = m_read(v.rs2, v);
      v.exp_wr      = !m_halted;
      v.exp_halted  = m_halted;
      v.exp_instret = m_instret;
      v.exp_last_pc = m_last_pc;
      drive(v);
      @(negedge clk);
      check_all($sformatf("rand%0d", n), v);
      prev_wr = !m_halted;
      model_edge(v);
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
